// File: rtl/ddr4_v2_2_20_mc_act_arb_if.sv
// ACT arbiter port bundle: the four group ports' requests plus the
// arbiter's grant, lookahead and block/drain handshake signals.
// master = request side (group ports, act timer, refresh/ZQ control),
// slave  = the arbiter.
interface ddr4_v2_2_20_mc_act_arb_if #(
    parameter int RKBITS    = 2,
    parameter int LR_WIDTH  = 1,
    parameter int RANK_SLAB = 4
);
    logic [3:0]            act_req;
    logic [3:0]            act_req_t;
    logic [4*RKBITS-1:0]   cmd_rank;
    logic [4*LR_WIDTH-1:0] cmd_lrank;
    logic                  block_req;
    logic                  block_ack;
    logic [3:0]            act_win_port_nxt;
    logic [RANK_SLAB-1:0]  act_rank_update;
    logic [3:0]            win_port;
    logic [RKBITS-1:0]     win_rank;
    logic [LR_WIDTH-1:0]   win_lrank;

    modport master (
        output act_req, act_req_t, cmd_rank, cmd_lrank, block_req,
        input  block_ack, act_win_port_nxt, act_rank_update,
               win_port, win_rank, win_lrank
    );

    modport slave (
        input  act_req, act_req_t, cmd_rank, cmd_lrank, block_req,
        output block_ack, act_win_port_nxt, act_rank_update,
               win_port, win_rank, win_lrank
    );
endinterface

// File: rtl/ddr4_v2_2_20_mc_act_arb.sv
// Activate-command arbiter: shares the single ACT issue slot among the four
// group ports. Requests are qualified by per-port timing-ok, one winner is
// picked round-robin, and the registered winner/rank is returned to the
// ports and act timer. A RUN/DRAIN/BLOCKED FSM lets refresh/ZQ stop ACT
// issue and wait for any in-flight grant to clear before acknowledging.
//
// Optional feature macro: ACT_ARB_STARVE_EN
//   defined   -> per-port loss counters; a port that has lost STARVE_MAX
//                times while eligible is granted ahead of round-robin.
//   undefined -> pure round-robin.
// Flops carry no clock-to-q delay; reset is synchronous, active-low.
module ddr4_v2_2_20_mc_act_arb #(
    parameter int RKBITS    = 2,
    parameter int LR_WIDTH  = 1,
    parameter int RANK_SLAB = 4
`ifdef ACT_ARB_STARVE_EN
    ,
    parameter int STARVE_MAX = 7
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    ddr4_v2_2_20_mc_act_arb_if.slave  bus
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_BLOCKED = 2'd2;

    logic [1:0]           state_reg, state_next;
    logic [1:0]           ptr_reg, ptr_next;
    logic [3:0]           win_port_reg, win_port_next;
    logic [RKBITS-1:0]    win_rank_reg, win_rank_next;
    logic [LR_WIDTH-1:0]  win_lrank_reg, win_lrank_next;

    logic [3:0]           elig;
    logic                 rr_any;
    logic [1:0]           rr_idx;
    logic                 grant_any;
    logic [1:0]           grant_idx;
    logic [3:0]           grant;
    logic [RKBITS-1:0]    grant_rank;
    logic [LR_WIDTH-1:0]  grant_lrank;
    logic [RANK_SLAB-1:0] rank_update;

    logic [RKBITS-1:0]    rank_arr  [4];
    logic [LR_WIDTH-1:0]  lrank_arr [4];

    genvar gi;

    // Unpack the per-port rank fields so the winner can be selected by index.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign rank_arr[gi]  = bus.cmd_rank[gi*RKBITS +: RKBITS];
            assign lrank_arr[gi] = bus.cmd_lrank[gi*LR_WIDTH +: LR_WIDTH];
        end
    endgenerate

    // A port competes only while running, out of reset, timing-ok, and not
    // in its ack cycle (it is still holding actReq then).
    assign elig = bus.act_req & bus.act_req_t & ~win_port_reg
                & {4{(state_reg == ST_RUN) && rst}};

    // Round-robin search starting at the pointer; first eligible port wins.
    always_comb begin
        rr_any = 1'b0;
        rr_idx = ptr_reg;
        for (int k = 0; k < 4; k++) begin
            if (!rr_any && elig[ptr_reg + 2'(k)]) begin
                rr_any = 1'b1;
                rr_idx = ptr_reg + 2'(k);
            end
        end
    end

`ifdef ACT_ARB_STARVE_EN
    localparam int SW = ($clog2(STARVE_MAX + 1) < 3) ? 3 : $clog2(STARVE_MAX + 1);

    logic [3:0] at_max;
    logic [3:0] starved;
    logic       starve_any;
    logic [1:0] starve_idx;

    // Per-port loss counters: count eligible-but-not-granted cycles,
    // saturate at the limit, clear when the port is granted.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_starve
            logic [SW-1:0] cnt_reg;

            // Loss counter for this port.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (grant[gi]) begin
                    cnt_reg <= '0;
                end else if (elig[gi] && (cnt_reg != SW'(STARVE_MAX))) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign at_max[gi] = (cnt_reg == SW'(STARVE_MAX));
        end
    endgenerate

    assign starved    = elig & at_max;
    assign starve_any = |starved;

    // Lowest-index starved port takes precedence over round-robin.
    always_comb begin
        starve_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (starved[k]) begin
                starve_idx = 2'(k);
            end
        end
    end

    assign grant_idx = starve_any ? starve_idx : rr_idx;
`else
    assign grant_idx = rr_idx;
`endif

    assign grant_any   = rr_any;
    assign grant_rank  = rank_arr[grant_idx];
    assign grant_lrank = lrank_arr[grant_idx];

    // One-hot winner and one-hot rank of the winner for the lookahead outputs.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_grant
            assign grant[gi] = grant_any && (grant_idx == 2'(gi));
        end
        for (gi = 0; gi < RANK_SLAB; gi++) begin : g_rank_upd
            assign rank_update[gi] = grant_any && (int'(grant_rank) == gi);
        end
    endgenerate

    // Next registered winner, rank hold and pointer advance past the winner.
    always_comb begin
        win_port_next  = grant;
        win_rank_next  = win_rank_reg;
        win_lrank_next = win_lrank_reg;
        ptr_next       = ptr_reg;
        if (grant_any) begin
            win_rank_next  = grant_rank;
            win_lrank_next = grant_lrank;
            ptr_next       = grant_idx + 2'd1;
        end
    end

    // Block/drain FSM: stop new grants, wait for the in-flight ack to clear.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (bus.block_req) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!bus.block_req)         state_next = ST_RUN;
                else if (win_port_reg == 4'b0) state_next = ST_BLOCKED;
            end
            ST_BLOCKED: begin
                if (!bus.block_req) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    // State, pointer and registered winner outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_RUN;
            ptr_reg       <= 2'd0;
            win_port_reg  <= 4'b0;
            win_rank_reg  <= '0;
            win_lrank_reg <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            win_port_reg  <= win_port_next;
            win_rank_reg  <= win_rank_next;
            win_lrank_reg <= win_lrank_next;
        end
    end

    assign bus.act_win_port_nxt = grant;
    assign bus.act_rank_update  = rank_update;
    assign bus.win_port         = win_port_reg;
    assign bus.win_rank         = win_rank_reg;
    assign bus.win_lrank        = win_lrank_reg;
    assign bus.block_ack        = (state_reg == ST_BLOCKED);

endmodule

// File: tb/tb_ddr4_v2_2_20_mc_act_arb.sv
// Bench for the ACT arbiter: directed scenarios for reset, ordering, timing
// gating, block/drain, pointer wrap and mid-grant reset, then randomized
// port traffic, all checked cycle by cycle against a behavioural model.
module tb_ddr4_v2_2_20_mc_act_arb;
    localparam int RKBITS    = 2;
    localparam int LR_WIDTH  = 1;
    localparam int RANK_SLAB = 4;
`ifdef ACT_ARB_STARVE_EN
    localparam int STARVE_MAX = 7;
`endif
    localparam int PH_RUN     = 0;
    localparam int PH_DRAIN   = 1;
    localparam int PH_BLOCKED = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ddr4_v2_2_20_mc_act_arb_if #(
        .RKBITS(RKBITS), .LR_WIDTH(LR_WIDTH), .RANK_SLAB(RANK_SLAB)
    ) bus ();

    ddr4_v2_2_20_mc_act_arb #(
        .RKBITS(RKBITS), .LR_WIDTH(LR_WIDTH), .RANK_SLAB(RANK_SLAB)
`ifdef ACT_ARB_STARVE_EN
        , .STARVE_MAX(STARVE_MAX)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state.
    logic [3:0] m_wport = 4'b0;
    int m_wrank = 0, m_wlrank = 0, m_ptr = 0, m_phase = PH_RUN;
    bit m_valid = 1'b0;
    int m_starve [4] = '{0, 0, 0, 0};

    int ranks  [4] = '{0, 0, 0, 0};
    int lranks [4] = '{0, 0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check the DUT
    // against the model mid-cycle, then advance the model past the next edge.
    task automatic step(input logic [3:0] req, input logic [3:0] reqt,
                        input logic blk, input logic rstv);
        int win;
        bit elig [4];
        logic [3:0] e_nxt;
        logic [RANK_SLAB-1:0] e_rupd;
        int new_phase;
        @(negedge clk);
        rst = rstv;
        bus.act_req   = req;
        bus.act_req_t = reqt;
        bus.block_req = blk;
        for (int p = 0; p < 4; p++) begin
            bus.cmd_rank[p*RKBITS +: RKBITS]      = RKBITS'(ranks[p]);
            bus.cmd_lrank[p*LR_WIDTH +: LR_WIDTH] = LR_WIDTH'(lranks[p]);
        end
        #1;
        win = -1;
        e_nxt = '0;
        e_rupd = '0;
        for (int p = 0; p < 4; p++)
            elig[p] = rstv && (m_phase == PH_RUN) && req[p] && reqt[p] && !m_wport[p];
`ifdef ACT_ARB_STARVE_EN
        for (int p = 3; p >= 0; p--)
            if (elig[p] && m_starve[p] == STARVE_MAX) win = p;
`endif
        if (win < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (win < 0 && elig[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
            end
        end
        if (win >= 0) begin
            e_nxt[win] = 1'b1;
            if (ranks[win] < RANK_SLAB) e_rupd[ranks[win]] = 1'b1;
        end
        chk("win_port_nxt", 32'(bus.act_win_port_nxt), 32'(e_nxt));
        chk("rank_update",  32'(bus.act_rank_update),  32'(e_rupd));
        if (m_valid) begin
            chk("win_port",  32'(bus.win_port),  32'(m_wport));
            chk("win_rank",  32'(bus.win_rank),  32'(m_wrank));
            chk("win_lrank", 32'(bus.win_lrank), 32'(m_wlrank));
            chk("block_ack", 32'(bus.block_ack), 32'(m_phase == PH_BLOCKED));
        end
        if (!rstv) begin
            m_wport = 4'b0; m_wrank = 0; m_wlrank = 0; m_ptr = 0;
            m_phase = PH_RUN; m_valid = 1'b1;
            for (int p = 0; p < 4; p++) m_starve[p] = 0;
        end else begin
            new_phase = m_phase;
            if (m_phase == PH_RUN && blk) new_phase = PH_DRAIN;
            else if (m_phase == PH_DRAIN && !blk) new_phase = PH_RUN;
            else if (m_phase == PH_DRAIN && m_wport == 4'b0) new_phase = PH_BLOCKED;
            else if (m_phase == PH_BLOCKED && !blk) new_phase = PH_RUN;
            m_phase = new_phase;
`ifdef ACT_ARB_STARVE_EN
            for (int p = 0; p < 4; p++) begin
                if (p == win) m_starve[p] = 0;
                else if (elig[p] && m_starve[p] < STARVE_MAX) m_starve[p]++;
            end
`endif
            m_wport = e_nxt;
            if (win >= 0) begin
                m_wrank  = ranks[win];
                m_wlrank = lranks[win];
                m_ptr    = (win + 1) % 4;
            end
        end
    endtask

    // Sample registered outputs just after the edge that follows a step.
    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] req_v;
    logic       blk_v;
    logic       rst_v;

    initial begin
        bus.act_req = '0; bus.act_req_t = '0; bus.block_req = 1'b0;
        bus.cmd_rank = '0; bus.cmd_lrank = '0;

        // Reset, then all ports requesting: strict 0,1,2,3,0 order.
        step(4'hF, 4'hF, 1'b0, 1'b0);
        step(4'hF, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            logic [3:0] exp_wp;
            exp_wp = 4'b0001 << (i % 4);
            step(4'hF, 4'hF, 1'b0, 1'b1);
            post_edge();
            chk("t1_order", 32'(bus.win_port), 32'(exp_wp));
        end

        // Timing-ok gating: no grant while actReqT low, grant 1 cycle after.
        step(4'h0, 4'h0, 1'b0, 1'b0);
        ranks[2] = 3; lranks[2] = 1;
        for (int i = 0; i < 5; i++) begin
            step(4'b0100, 4'b0000, 1'b0, 1'b1);
            post_edge();
            chk("t2_gated", 32'(bus.win_port), 32'h0);
        end
        step(4'b0100, 4'b0100, 1'b0, 1'b1);
        post_edge();
        chk("t2_win_port",  32'(bus.win_port),  32'b0100);
        chk("t2_win_rank",  32'(bus.win_rank),  32'd3);
        chk("t2_win_lrank", 32'(bus.win_lrank), 32'd1);
        ranks[2] = 0; lranks[2] = 0;

        // Block request arriving with a grant decision.
        step(4'h0, 4'h0, 1'b0, 1'b0);
        step(4'b0001, 4'hF, 1'b1, 1'b1);
        post_edge();
        chk("t3_inflight", 32'(bus.win_port), 32'b0001);
        for (int i = 0; i < 10; i++) step(4'hF, 4'hF, 1'b1, 1'b1);
        post_edge();
        chk("t3_block_ack", 32'(bus.block_ack), 32'd1);
        chk("t3_no_grant",  32'(bus.win_port),  32'h0);
        step(4'hF, 4'hF, 1'b0, 1'b1);
        post_edge();
        chk("t3_ack_drop", 32'(bus.block_ack), 32'd0);
        step(4'hF, 4'hF, 1'b0, 1'b1);
        post_edge();
        chk("t3_resume", 32'(bus.win_port), 32'b0010);

        // Pointer wrap after port 3.
        step(4'h0, 4'h0, 1'b0, 1'b0);
        step(4'b0100, 4'hF, 1'b0, 1'b1);
        step(4'b0000, 4'hF, 1'b0, 1'b1);
        step(4'b1000, 4'hF, 1'b0, 1'b1);
        post_edge();
        chk("t4_port3", 32'(bus.win_port), 32'b1000);
        step(4'b0101, 4'hF, 1'b0, 1'b1);
        post_edge();
        chk("t4_wrap", 32'(bus.win_port), 32'b0001);

        // Reset while a grant is out and the FSM is draining.
        step(4'h0, 4'h0, 1'b0, 1'b0);
        ranks[1] = 2; lranks[1] = 1;
        step(4'b0001, 4'hF, 1'b0, 1'b1);
        step(4'b0010, 4'hF, 1'b1, 1'b1);
        post_edge();
        chk("t5_pre", 32'(bus.win_port), 32'b0010);
        step(4'hF, 4'hF, 1'b1, 1'b0);
        post_edge();
        chk("t5_win_port",  32'(bus.win_port),  32'h0);
        chk("t5_win_rank",  32'(bus.win_rank),  32'h0);
        chk("t5_win_lrank", 32'(bus.win_lrank), 32'h0);
        chk("t5_block_ack", 32'(bus.block_ack), 32'h0);
        step(4'hF, 4'hF, 1'b0, 1'b1);
        post_edge();
        chk("t5_ptr0", 32'(bus.win_port), 32'b0001);

        // Randomized traffic: ports hold requests until acked, then drop.
        req_v = 4'b0;
        blk_v = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 4; p++) begin
                if (m_wport[p]) begin
                    req_v[p] = 1'b0;
                end else if (!req_v[p] && $urandom_range(0, 2) == 0) begin
                    req_v[p]  = 1'b1;
                    ranks[p]  = $urandom_range(0, 3);
                    lranks[p] = $urandom_range(0, 1);
                end
            end
            if ($urandom_range(0, 15) == 0) blk_v = ~blk_v;
            rst_v = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step(req_v, 4'($urandom_range(0, 15)), blk_v, rst_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
